// File: rtl/hazard_detection_unit_if.sv
// Hazard detection interface: bundles the ID/EX/MEM register-use information
// seen by the hazard unit and the pipeline-control outputs it produces.
//   slave  : hazard unit side (consumes pipeline info, drives stall/flush controls)
//   master : pipeline side (drives pipeline info, consumes stall/flush controls)
//   IDrs/IDrt/IDusesRt/IDBranch/BranchTaken : ID-stage instruction info
//   EXRegWrite/EXMemRead/EXrd               : EX-stage destination info
//   MemRegWrite/Memrd                       : MEM-stage destination info
//   PCWrite/IFIDWrite/IDEXBubble/IFIDFlush  : pipeline control (Mealy in RUN)
//   StallActive/StallCount                  : stall status and bubble counter
interface hazard_detection_unit_if;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  logic [REG_W-1:0] IDrs;
  logic [REG_W-1:0] IDrt;
  logic             IDusesRt;
  logic             IDBranch;
  logic             BranchTaken;
  logic             EXRegWrite;
  logic             EXMemRead;
  logic [REG_W-1:0] EXrd;
  logic             MemRegWrite;
  logic [REG_W-1:0] Memrd;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEXBubble;
  logic             IFIDFlush;
  logic             StallActive;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output IDrs, IDrt, IDusesRt, IDBranch, BranchTaken,
    output EXRegWrite, EXMemRead, EXrd, MemRegWrite, Memrd,
    input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, StallActive, StallCount
  );

  modport slave (
    input  IDrs, IDrt, IDusesRt, IDBranch, BranchTaken,
    input  EXRegWrite, EXMemRead, EXrd, MemRegWrite, Memrd,
    output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, StallActive, StallCount
  );
endinterface

// File: rtl/hazard_detection_unit.sv
// Hazard detection unit for a 5-stage pipeline with branches resolved in ID.
// Detects load-use and branch-operand hazards and stalls the front end
// (freeze PC and IF/ID, bubble ID/EX) for one or two cycles.
//   Clk   : rising-edge clock
//   Reset : synchronous active-high reset
//   bus   : hazard_detection_unit_if.slave (pipeline info in, controls out)
module hazard_detection_unit (
  input  logic                      Clk,
  input  logic                      Reset,
  hazard_detection_unit_if.slave    bus
);
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t           state;
  state_t           next_state;
  logic             ex_match;
  logic             mem_match;
  logic             h1;
  logic             h2;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             stall_active;
  logic [CNT_W-1:0] stall_count;

  // rd produces a value the ID instruction reads (r0 never creates a hazard)
  function automatic logic reg_match(input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             uses_rt);
    return (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

  assign ex_match  = reg_match(bus.EXrd,  bus.IDrs, bus.IDrt, bus.IDusesRt);
  assign mem_match = reg_match(bus.Memrd, bus.IDrs, bus.IDrt, bus.IDusesRt);

  // Branch needs an EX result that is only available at WB: two bubbles
  assign h2 = bus.IDBranch && bus.EXRegWrite && ex_match;
  // Branch on a MEM result, or non-branch use of a load in EX: one bubble
  assign h1 = (bus.IDBranch && bus.MemRegWrite && mem_match) ||
              (!bus.IDBranch && bus.EXMemRead && ex_match);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= RUN;
    else       state <= next_state;
  end

  // Next state and Mealy pipeline controls; Reset forces the idle outputs
  always_comb begin
    next_state   = state;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_bubble  = 1'b0;
    ifid_flush   = 1'b0;
    stall_active = 1'b0;
    if (Reset) begin
      next_state = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (h2 || h1) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            next_state  = h2 ? STALL : RUN;
          end else begin
            ifid_flush = bus.BranchTaken;
          end
        end
        STALL: begin
          // Second bubble of a branch-after-ALU stall; hazards not re-checked
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_bubble  = 1'b1;
          stall_active = 1'b1;
          next_state   = RUN;
        end
        default: next_state = RUN;
      endcase
    end
  end

  // Saturating count of issued bubbles
  always_ff @(posedge Clk) begin
    if (Reset)
      stall_count <= '0;
    else if (idex_bubble && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + CNT_W'(1);
  end

  assign bus.PCWrite     = pc_write;
  assign bus.IFIDWrite   = ifid_write;
  assign bus.IDEXBubble  = idex_bubble;
  assign bus.IFIDFlush   = ifid_flush;
  assign bus.StallActive = stall_active;
  assign bus.StallCount  = stall_count;
endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: single-cycle vector table,
// directed multi-cycle sequences, and randomized traffic against a model
// that tracks the number of remaining forced bubble cycles.
module tb_hazard_detection_unit;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  hazard_detection_unit_if hif ();

  hazard_detection_unit dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pend = bubbles still owed from an earlier hazard
  int          pend;
  int unsigned mcount;

  // Last sampled DUT values, for directed checks against constants
  logic        s_pc, s_ifid, s_bub, s_fl, s_act;
  logic [15:0] s_cnt;

  function automatic bit mt(input logic [4:0] rd);
    return (rd != 0) && (rd == hif.IDrs || (hif.IDusesRt && rd == hif.IDrt));
  endfunction

  // Bubbles a fresh hazard demands, from the hazard rules directly
  function automatic int need_bubbles();
    if (hif.IDBranch && hif.EXRegWrite && mt(hif.EXrd)) return 2;
    if (hif.IDBranch && hif.MemRegWrite && mt(hif.Memrd)) return 1;
    if (!hif.IDBranch && hif.EXMemRead && mt(hif.EXrd)) return 1;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                        input logic br, input logic tk, input logic exw, input logic exm,
                        input logic [4:0] exrd, input logic memw, input logic [4:0] memrd);
    hif.IDrs = rs; hif.IDrt = rt; hif.IDusesRt = ur; hif.IDBranch = br;
    hif.BranchTaken = tk; hif.EXRegWrite = exw; hif.EXMemRead = exm;
    hif.EXrd = exrd; hif.MemRegWrite = memw; hif.Memrd = memrd;
  endtask

  task automatic clear_in();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  // Called just after a falling edge with inputs applied: sample, compare
  // with the model, advance through the rising edge, end at the next falling edge
  task automatic step(input string nm, input bit quiet = 1'b0);
    logic e_pc, e_bub, e_fl, e_act;
    int   n;
    #1;
    n = need_bubbles();
    if (reset) begin
      e_pc = 1; e_bub = 0; e_fl = 0; e_act = 0;
    end else if (pend > 0) begin
      e_pc = 0; e_bub = 1; e_fl = 0; e_act = 1;
    end else if (n > 0) begin
      e_pc = 0; e_bub = 1; e_fl = 0; e_act = 0;
    end else begin
      e_pc = 1; e_bub = 0; e_fl = hif.BranchTaken; e_act = 0;
    end
    s_pc = hif.PCWrite; s_ifid = hif.IFIDWrite; s_bub = hif.IDEXBubble;
    s_fl = hif.IFIDFlush; s_act = hif.StallActive; s_cnt = hif.StallCount;
    if (!quiet) begin
      chk({nm, ".PCWrite"},     16'(s_pc),   16'(e_pc));
      chk({nm, ".IFIDWrite"},   16'(s_ifid), 16'(e_pc));
      chk({nm, ".IDEXBubble"},  16'(s_bub),  16'(e_bub));
      chk({nm, ".IFIDFlush"},   16'(s_fl),   16'(e_fl));
      chk({nm, ".StallActive"}, 16'(s_act),  16'(e_act));
      chk({nm, ".StallCount"},  s_cnt,       16'(mcount));
    end
    @(posedge clk);
    if (reset) begin
      pend = 0; mcount = 0;
    end else begin
      if (e_bub && mcount < 32'hFFFF) mcount++;
      if (pend > 0) pend--;
      else if (n > 0) pend = n - 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; clear_in();
    step("reset");
    reset = 1'b0;
  endtask

  typedef struct {
    logic [4:0] rs, rt;
    logic       ur, br, tk, exw, exm;
    logic [4:0] exrd;
    logic       memw;
    logic [4:0] memrd;
    logic       e_pc, e_bub, e_fl;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                              input logic br, input logic tk, input logic exw, input logic exm,
                              input logic [4:0] exrd, input logic memw, input logic [4:0] memrd,
                              input logic e_pc, input logic e_bub, input logic e_fl);
    vec_t v;
    v.rs = rs; v.rt = rt; v.ur = ur; v.br = br; v.tk = tk; v.exw = exw; v.exm = exm;
    v.exrd = exrd; v.memw = memw; v.memrd = memrd; v.e_pc = e_pc; v.e_bub = e_bub; v.e_fl = e_fl;
    return v;
  endfunction

  vec_t tbl[9];

  initial begin
    total = 0; bad = 0; pend = 0; mcount = 0;
    reset = 1'b1; clear_in();
    @(negedge clk);

    //            rs  rt  ur br tk exw exm exrd memw memrd   pc bub fl
    tbl[0] = mk(5'd1, 5'd2, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0,     1, 0, 0);
    tbl[1] = mk(5'd1, 5'd2, 1, 1, 1, 0, 0, 5'd0, 0, 5'd0,     1, 0, 1);
    tbl[2] = mk(5'd3, 5'd2, 0, 0, 0, 1, 1, 5'd3, 0, 5'd0,     0, 1, 0);
    tbl[3] = mk(5'd1, 5'd4, 1, 0, 0, 1, 1, 5'd4, 0, 5'd0,     0, 1, 0);
    tbl[4] = mk(5'd1, 5'd4, 0, 0, 0, 1, 1, 5'd4, 0, 5'd0,     1, 0, 0);
    tbl[5] = mk(5'd0, 5'd0, 1, 0, 0, 1, 1, 5'd0, 0, 5'd0,     1, 0, 0);
    tbl[6] = mk(5'd7, 5'd2, 1, 1, 1, 1, 0, 5'd7, 0, 5'd0,     0, 1, 0);
    tbl[7] = mk(5'd6, 5'd2, 1, 1, 1, 0, 0, 5'd0, 1, 5'd6,     0, 1, 0);
    tbl[8] = mk(5'd5, 5'd2, 1, 0, 0, 1, 0, 5'd5, 1, 5'd5,     1, 0, 0);

    do_reset();
    chk("reset.StallCount", s_cnt, 16'h0000);
    chk("reset.PCWrite", 16'(s_pc), 16'h1);

    // Single-cycle table, each from a fresh RUN state
    foreach (tbl[i]) begin
      do_reset();
      set_in(tbl[i].rs, tbl[i].rt, tbl[i].ur, tbl[i].br, tbl[i].tk, tbl[i].exw,
             tbl[i].exm, tbl[i].exrd, tbl[i].memw, tbl[i].memrd);
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.pc", i),  16'(s_pc),  16'(tbl[i].e_pc));
      chk($sformatf("tbl%0d.bub", i), 16'(s_bub), 16'(tbl[i].e_bub));
      chk($sformatf("tbl%0d.fl", i),  16'(s_fl),  16'(tbl[i].e_fl));
    end

    // Load-use: one bubble then RUN, count 1
    do_reset();
    set_in(5'd8, 5'd0, 0, 0, 0, 1, 1, 5'd8, 0, 5'd0);
    step("lu1");
    chk("lu1.pc", 16'(s_pc), 16'h0);
    chk("lu1.bub", 16'(s_bub), 16'h1);
    clear_in(); hif.MemRegWrite = 1; hif.Memrd = 5'd8; hif.IDrs = 5'd8;
    step("lu2");
    chk("lu2.pc", 16'(s_pc), 16'h1);
    chk("lu2.act", 16'(s_act), 16'h0);
    chk("lu2.cnt", s_cnt, 16'd1);

    // Branch after ALU op: two bubbles, StallActive only on the second
    do_reset();
    set_in(5'd0, 5'd9, 1, 1, 0, 1, 0, 5'd9, 0, 5'd0);
    step("br1");
    chk("br1.bub", 16'(s_bub), 16'h1);
    chk("br1.act", 16'(s_act), 16'h0);
    set_in(5'd0, 5'd9, 1, 1, 0, 0, 0, 5'd0, 1, 5'd9);
    step("br2");
    chk("br2.bub", 16'(s_bub), 16'h1);
    chk("br2.act", 16'(s_act), 16'h1);
    set_in(5'd0, 5'd9, 1, 1, 0, 0, 0, 5'd0, 0, 5'd0);
    step("br3");
    chk("br3.bub", 16'(s_bub), 16'h0);
    chk("br3.act", 16'(s_act), 16'h0);
    chk("br3.cnt", s_cnt, 16'd2);

    // Zero register never stalls
    do_reset();
    set_in(5'd0, 5'd0, 1, 0, 0, 1, 1, 5'd0, 0, 5'd0);
    for (int k = 0; k < 3; k++) begin
      step("zero");
      chk("zero.pc", 16'(s_pc), 16'h1);
    end

    // Taken branch held off by H1: no flush while stalled, flush once after
    do_reset();
    set_in(5'd5, 5'd0, 0, 1, 1, 0, 0, 5'd0, 1, 5'd5);
    step("tk1");
    chk("tk1.fl", 16'(s_fl), 16'h0);
    chk("tk1.bub", 16'(s_bub), 16'h1);
    set_in(5'd5, 5'd0, 0, 1, 1, 0, 0, 5'd0, 0, 5'd0);
    step("tk2");
    chk("tk2.fl", 16'(s_fl), 16'h1);
    clear_in();
    step("tk3");
    chk("tk3.fl", 16'(s_fl), 16'h0);

    // Taken branch under H2: flush suppressed in both stall cycles
    do_reset();
    set_in(5'd3, 5'd0, 0, 1, 1, 1, 0, 5'd3, 0, 5'd0);
    step("tkh2a");
    chk("tkh2a.fl", 16'(s_fl), 16'h0);
    step("tkh2b");
    chk("tkh2b.fl", 16'(s_fl), 16'h0);
    chk("tkh2b.act", 16'(s_act), 16'h1);

    // Reset mid-stall aborts the second bubble
    do_reset();
    set_in(5'd9, 5'd0, 0, 1, 0, 1, 0, 5'd9, 0, 5'd0);
    step("rs1");
    chk("rs1.bub", 16'(s_bub), 16'h1);
    reset = 1'b1;
    step("rs2");
    chk("rs2.bub", 16'(s_bub), 16'h0);
    chk("rs2.act", 16'(s_act), 16'h0);
    chk("rs2.pc", 16'(s_pc), 16'h1);
    reset = 1'b0; clear_in();
    step("rs3");
    chk("rs3.bub", 16'(s_bub), 16'h0);
    chk("rs3.act", 16'(s_act), 16'h0);
    chk("rs3.cnt", s_cnt, 16'd0);

    // Saturation: continuous load-use hazard
    do_reset();
    set_in(5'd8, 5'd0, 0, 0, 0, 1, 1, 5'd8, 0, 5'd0);
    for (int k = 0; k < 65534; k++) step("pre", 1'b1);
    step("sat0");
    chk("sat0.cnt", s_cnt, 16'hFFFE);
    step("sat1");
    chk("sat1.cnt", s_cnt, 16'hFFFF);
    for (int k = 0; k < 3; k++) step("sat2");
    chk("sat2.cnt", s_cnt, 16'hFFFF);

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 500; k++) begin
      reset = ($urandom_range(0, 24) == 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)));
      step($sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
